// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and clocking defaults.
// Used by the TX serializer, the baud counter and the future RX deserializer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uartState_t;

    localparam int CLKS_PER_BIT_DEFAULT = 217;  // 25 MHz / 115200 baud
    localparam int CLK_PERIOD_NS        = 40;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: free-runs 0..CLKS_PER_BIT-1 while not cleared, flags the last cycle.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baudCnt;

    // Wrapping exactly at the terminal count keeps every bit CLKS_PER_BIT long.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baudCnt <= '0;
        end else if (clear || baudCnt == LAST_CNT) begin
            baudCnt <= '0;
        end else begin
            baudCnt <= baudCnt + 1'b1;
        end
    end

    assign bit_end = (baudCnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer behind bufferTx: start, LSB-first data, stop bit(s).
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    // state  | meaning
    // IDLE   | line high, waiting for a byte from bufferTx
    // START  | start bit (low)
    // DATA   | data bits, LSB first
    // PARITY | even parity bit (UART_TX_PARITY_EN only)
    // STOP   | stop bit(s), done on the final cycle

    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    uartState_t           state;
    uartState_t           nextState;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic [BIT_CNT_W-1:0] bitCnt;
    logic [BIT_CNT_W-1:0] bitCntNext;
    logic                 bitEnd;
    logic                 baudClear;
    logic                 transfer;
    logic                 lastData;
    logic                 lastStop;
    logic                 txNext;

    assign baudClear = (state == IDLE);
    assign transfer  = inValid && (state == IDLE);
    assign lastData  = (bitCnt == LAST_DATA);
    assign lastStop  = (bitCnt == LAST_STOP);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudCounter (
        .clk    (clk),
        .rst    (rst),
        .clear  (baudClear),
        .bit_end(bitEnd)
    );

`ifdef UART_TX_PARITY_EN
    logic parityBit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parityBit <= 1'b0;
        end else if (transfer) begin
            parityBit <= ^data_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (inValid) nextState = START;
            START:   if (bitEnd) nextState = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:    if (bitEnd && lastData) nextState = PARITY;
            PARITY:  if (bitEnd) nextState = STOP;
`else
            DATA:    if (bitEnd && lastData) nextState = STOP;
`endif
            STOP:    if (bitEnd && lastStop) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        inReady = (state == IDLE);
        busy    = (state != IDLE);
        done    = (state == STOP) && bitEnd && lastStop;
        // tx is registered, so it is computed from where the FSM is heading.
        txNext  = 1'b1;
        case (nextState)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txNext = parityBit;
`endif
            default: txNext = 1'b1;
        endcase
    end

    always_comb begin
        shiftNext  = shiftReg;
        bitCntNext = bitCnt;
        case (state)
            IDLE: begin
                if (transfer) begin
                    shiftNext  = data_in;
                    bitCntNext = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftNext  = shiftReg >> 1;
                    bitCntNext = lastData ? '0 : bitCnt + 1'b1;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    bitCntNext = lastStop ? '0 : bitCnt + 1'b1;
                end
            end
            default: begin
                shiftNext  = shiftReg;
                bitCntNext = bitCnt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftReg <= '0;
            bitCnt   <= '0;
            tx       <= 1'b1;
        end else begin
            shiftReg <= shiftNext;
            bitCnt   <= bitCntNext;
            tx       <= txNext;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=8; line activity is logged per cycle.
// Builds with or without UART_TX_PARITY_EN and adjusts the expected frame accordingly.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [10:0] A5_LINE = 11'h54A;  // 0,1,0,1,0,0,1,0,1,0,1
`else
    localparam int NBITS = 10;
    localparam logic [10:0] A5_LINE = 11'h34A;  // 0,1,0,1,0,0,1,0,1,1
`endif
    localparam int FLEN = NBITS * CPB;
    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid;
    logic       inReady;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       done;

    int   cyc = 0;
    int   assertCount = 0;
    int   failCount = 0;
    logic txLog   [LOGN];
    logic doneLog [LOGN];
    logic rdyLog  [LOGN];
    logic busyLog [LOGN];

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .inValid(inValid),
        .inReady(inReady),
        .data_in(data_in),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            txLog[cyc]   <= tx;
            doneLog[cyc] <= done;
            rdyLog[cyc]  <= inReady;
            busyLog[cyc] <= busy;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [10:0] frameBits(input logic [7:0] b);
        logic [10:0] r;
        r      = '1;
        r[0]   = 1'b0;
        r[8:1] = b;
`ifdef UART_TX_PARITY_EN
        r[9]   = ^b;
`endif
        return r;
    endfunction

    function automatic logic [10:0] midBits(input int t0);
        logic [10:0] r;
        r = '0;
        for (int i = 0; i < NBITS; i++) r[i] = txLog[t0 + i * CPB + CPB / 2];
        return r;
    endfunction

    task automatic waitUntil(input int idx);
        while (cyc <= idx + 1) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic hold, output int t0);
        int w;
        w = 0;
        @(negedge clk);
        while (inReady !== 1'b1 && w < 4 * FLEN) begin
            @(negedge clk);
            w++;
        end
        checkVal("ready wait", {31'd0, inReady}, 1);
        data_in = b;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) begin
            @(negedge clk);
            inValid = 1'b0;
        end
    endtask

    task automatic checkFrame(input string tag, input int t0, input logic [7:0] b);
        logic [10:0] expBits;
        logic [10:0] mid;
        int bad;
        int doneCnt;
        int doneAt;
        int rdy;
        expBits = frameBits(b);
        bad = 0;
        doneCnt = 0;
        doneAt = -1;
        rdy = 0;
        for (int i = 0; i < NBITS; i++)
            for (int j = 0; j < CPB; j++)
                if (txLog[t0 + i * CPB + j] !== expBits[i]) bad++;
        checkVal({tag, " bit timing"}, bad, 0);
        mid = midBits(t0);
        checkVal({tag, " data"}, {24'd0, mid[8:1]}, {24'd0, b});
        for (int k = t0; k < t0 + FLEN + CPB; k++) begin
            if (doneLog[k] === 1'b1) begin
                doneCnt++;
                if (doneAt < 0) doneAt = k - t0 + 1;
            end
            if (k < t0 + FLEN && rdyLog[k] !== 1'b0) rdy++;
        end
        checkVal({tag, " done cycle"}, doneAt, FLEN);
        checkVal({tag, " done count"}, doneCnt, 1);
        checkVal({tag, " ready in frame"}, rdy, 0);
    endtask

    initial begin
        #(CLK_PERIOD_NS * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int t2;
        int gap;
        int cnt;
        int ts [4];
        logic [10:0] mid;
        // bufferTx output order for word 0x0000F0F0
        logic [7:0] chainBytes [4] = '{8'hF0, 8'hF0, 8'h00, 8'h00};

        rst = 1'b0;
        inValid = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        checkVal("reset tx", {31'd0, tx}, 1);
        checkVal("reset inReady", {31'd0, inReady}, 1);
        checkVal("reset busy", {31'd0, busy}, 0);
        checkVal("reset done", {31'd0, done}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        sendByte(8'hA5, 1'b0, t0);
        waitUntil(t0 + FLEN + CPB);
        checkFrame("A5", t0, 8'hA5);
        checkVal("A5 latency", {30'd0, txLog[t0 - 1], txLog[t0]}, 2'b10);
        mid = midBits(t0);
        checkVal("A5 line", {21'd0, mid}, {21'd0, A5_LINE});
        checkVal("A5 idle after", {30'd0, txLog[t0 + FLEN], rdyLog[t0 + FLEN]}, 2'b11);
`ifdef UART_TX_PARITY_EN
        checkVal("A5 parity", {31'd0, mid[9]}, 0);
`endif

        sendByte(8'h00, 1'b1, t1);
        sendByte(8'hFF, 1'b0, t2);
        waitUntil(t2 + FLEN + CPB);
        checkFrame("b2b 00", t1, 8'h00);
        checkFrame("b2b FF", t2, 8'hFF);
        gap = 0;
        for (int k = t1 + FLEN - CPB; k < t1 + FLEN + 2 * CPB && txLog[k] === 1'b1; k++) gap++;
        checkVal("b2b line high", gap, CPB + 1);

        sendByte(8'h81, 1'b0, t0);
        while (cyc < t0 + 20) @(negedge clk);
        data_in = 8'h3C;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        waitUntil(t0 + FLEN + 30);
        checkFrame("ignore 81", t0, 8'h81);
        cnt = 0;
        for (int k = t0 + FLEN; k < t0 + FLEN + 30; k++)
            if (txLog[k] !== 1'b1 || busyLog[k] !== 1'b0) cnt++;
        checkVal("ignore no 3C frame", cnt, 0);

        sendByte(8'hFF, 1'b0, t0);
        while (cyc < t0 + 29) @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("midreset tx", {31'd0, tx}, 1);
        checkVal("midreset busy", {31'd0, busy}, 0);
        checkVal("midreset inReady", {31'd0, inReady}, 1);
        checkVal("midreset done", {31'd0, done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        waitUntil(t0 + FLEN + CPB);
        cnt = 0;
        for (int k = t0; k < t0 + FLEN + CPB; k++) if (doneLog[k] !== 1'b0) cnt++;
        checkVal("midreset no done", cnt, 0);
        sendByte(8'h55, 1'b0, t0);
        waitUntil(t0 + FLEN + CPB);
        checkFrame("after reset 55", t0, 8'h55);

`ifdef UART_TX_PARITY_EN
        sendByte(8'h07, 1'b0, t0);
        waitUntil(t0 + FLEN + CPB);
        checkFrame("parity 07", t0, 8'h07);
        mid = midBits(t0);
        checkVal("07 parity", {31'd0, mid[9]}, 1);
`endif

        for (int i = 0; i < 4; i++) sendByte(chainBytes[i], (i < 3) ? 1'b1 : 1'b0, ts[i]);
        waitUntil(ts[3] + FLEN + CPB);
        for (int i = 0; i < 4; i++) checkFrame($sformatf("chain %0d", i), ts[i], chainBytes[i]);
        cnt = 0;
        for (int k = ts[0]; k < ts[3] + FLEN + CPB; k++) if (doneLog[k] === 1'b1) cnt++;
        checkVal("chain done pulses", cnt, 4);

        cnt = 0;
        for (int k = 2; k < cyc - 2; k++) if (rdyLog[k] === busyLog[k]) cnt++;
        checkVal("inReady only in idle", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serial UART transmitter sitting directly downstream of bufferTx.
- Accepts one byte per valid/ready handshake from bufferTx (its data_out/outValid/outReady side).
- Emits a standard 8N1 frame on the tx line: start bit, 8 data bits LSB first, stop bit(s).
- Each bit is held for CLKS_PER_BIT clocks. Target is 25 MHz / 115200 baud = 217 clocks per bit.

Parameters:
- CLKS_PER_BIT, 217: clocks per serial bit; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; fixed at 8 for this release, data_in width follows it.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- inValid  input  1  upstream byte valid (driven by bufferTx outValid).
- inReady  output  1  serializer can accept a byte (drives bufferTx outReady).
- data_in  input  DATA_BITS  byte to send (from bufferTx data_out).
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (rst low, async): state=IDLE, tx=1, inReady=1, busy=0, done=0; baud and bit counters cleared; shift register cleared.
- Reset asserted mid-frame: the frame is abandoned immediately and tx returns high in the same cycle. No done pulse. The byte is lost.
- Handshake: inReady = (state==IDLE).
  - Transfer occurs on a rising edge with inValid && inReady; data_in is latched into the shift register.
  - inValid while busy is ignored; data_in changes after capture have no effect.
- States and transitions:
  - IDLE: tx=1; on transfer -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; bit counter 0..DATA_BITS-1; after the last bit -> PARITY (if enabled) else STOP.
  - PARITY: see Optional Feature.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE; done pulses on the final cycle.
- Latency: tx falls on the first clock after the transfer edge.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: with inValid held high, the next transfer happens in the first IDLE cycle. Line high time between frames = STOP_BITS*CLKS_PER_BIT+1 cycles.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. No cumulative drift allowed: each bit lasts exactly CLKS_PER_BIT cycles.
- tx is driven from a flop (registered output, glitch-free).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA, holding tx = even parity (XOR of all data bits) for CLKS_PER_BIT cycles. Frame grows by one bit.
- Undefined: no PARITY state and no parity logic; frame is 8N1 exactly.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - the default CLKS_PER_BIT localparam (217);
  - localparam CLK_PERIOD_NS=40.
- One natural sub-module, uart_baud_counter:
  - inputs: clk, rst, clear;
  - output: bit_end pulse asserted when the count reaches CLKS_PER_BIT-1.
  - The RX deserializer will reuse it.

Test Plan (bench sets CLKS_PER_BIT=8):
- Single byte 0xA5 sent after reset:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 8 cycles (80 cycles total);
  - done pulses at cycle 80 after the transfer;
  - inReady is low throughout the frame.
- Back-to-back 0x00 then 0xFF with inValid held high:
  - second start bit falls 9 cycles after the first frame's stop bit begins;
  - sampling tx mid-bit decodes both bytes correctly.
- inValid pulsed with 0x3C mid-frame while sending 0x81:
  - 0x3C is ignored; only 0x81 appears on tx;
  - inReady is high only in IDLE.
- rst driven low at cycle 30 of a 0xFF frame:
  - tx=1 and busy=0 immediately;
  - no done pulse;
  - a following byte 0x55 transmits cleanly.
- UART_TX_PARITY_EN defined:
  - 0xA5 yields parity bit 0; 0x07 yields parity bit 1;
  - frame length is 88 cycles.
- Chained with bufferTx, which is fed word 0x0000F0F0:
  - bytes 0xF0, 0xF0, 0x00, 0x00 appear on tx in bufferTx output order;
  - four done pulses are observed.
